_regfile_nway: RTL and testbench

- Parametrised register file: DEPTH words of WIDTH bits, one write port, two independent read ports.
- Generalises the 8-way 16-bit mux selection into an N-way read path over stored state.
- Adds optional registered reads, write-to-read forwarding, per-entry valid tracking and synchronous bulk clear.
- Serves as the storage primitive for the upcoming RAMn and CPU register blocks.

---
 rtl/_regfile_nway_pkg.sv | 12 +
 rtl/_regfile_nway_muxnway.sv | 54 +++++
 rtl/_regfile_nway.sv | 134 +++++++++++++
 tb/tb__regfile_nway.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/_regfile_nway_pkg.sv
// Shared constants for the N-way register file.
//   RD_COMB / RD_REG : values of the READ_REG parameter (0-cycle / 1-cycle read).
//   BYP_OFF / BYP_ON : values of the BYPASS parameter (no forwarding / write-to-read forwarding).
package _regfile_nway_pkg;

  localparam int RD_COMB = 0;
  localparam int RD_REG  = 1;

  localparam int BYP_OFF = 0;
  localparam int BYP_ON  = 1;

endpackage

// File: rtl/_regfile_nway_muxnway.sv
// N-way, WIDTH-bit multiplexer tree built from log2(N) stages of 2:1 muxes.
//   _mux     : out_y = sel ? in_b : in_a
//   _muxnway : out_y = entry `sel` of in_bus (entry 0 occupies the first WIDTH bits).
// All vectors run [0:N-1] with bit 0 as the MSB, so sel[SEL_W-1] is the
// address LSB. Stage k of the tree is steered by sel[SEL_W-1-k], which means
// the LSB picks between neighbouring entries first.

module _mux #(
  parameter int WIDTH = 1
) (
  output logic [0:WIDTH-1] out_y,
  input  logic [0:WIDTH-1] in_a,
  input  logic [0:WIDTH-1] in_b,
  input  logic             sel
);

  assign out_y = sel ? in_b : in_a;

endmodule

module _muxnway #(
  parameter  int N     = 8,
  parameter  int WIDTH = 16,
  localparam int SEL_W = $clog2(N)
) (
  output logic [0:WIDTH-1]   out_y,
  input  logic [0:N*WIDTH-1] in_bus,
  input  logic [0:SEL_W-1]   sel
);

  // Level 0 holds the N leaf words; level k holds N>>k words. Each level is
  // its own array so no variable feeds back into itself.
  for (genvar k = 0; k <= SEL_W; k++) begin : g_lvl
    logic [0:WIDTH-1] node [0:(N>>k)-1];

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_in
        assign node[i] = in_bus[i*WIDTH +: WIDTH];
      end
    end else begin : g_stage
      for (genvar j = 0; j < (N >> k); j++) begin : g_pair
        _mux #(.WIDTH(WIDTH)) u_mux (
          .out_y (node[j]),
          .in_a  (g_lvl[k-1].node[2*j]),
          .in_b  (g_lvl[k-1].node[2*j+1]),
          .sel   (sel[SEL_W-k])
        );
      end
    end
  end

  assign out_y = g_lvl[SEL_W].node[0];

endmodule

// File: rtl/_regfile_nway.sv
// Parametrised register file: DEPTH words of WIDTH bits, one write port and
// two independent read ports, with per-entry valid bits and bulk clear.
//   in_clk, in_rst_n        : clock, asynchronous active-low reset
//   in_load/in_waddr/in_d   : write port (accepted every cycle, no stall)
//   in_clear                : synchronous clear of all data and valid bits;
//                             wins over a simultaneous load
//   in_raddr_a/in_raddr_b   : read addresses
//   out_a/out_b             : read data
//   out_valid_a/out_valid_b : entry written since the last reset or clear
// READ_REG selects combinational (RD_COMB) or registered (RD_REG) reads.
// BYPASS forwards a same-cycle write to a matching read port; registered
// reads then become write-first, otherwise read-first.
module _regfile_nway
  import _regfile_nway_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 8,
  parameter  int READ_REG = RD_COMB,
  parameter  int BYPASS   = BYP_ON,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_load,
  input  logic [0:ADDR_W-1] in_waddr,
  input  logic [0:WIDTH-1]  in_d,
  input  logic              in_clear,
  input  logic [0:ADDR_W-1] in_raddr_a,
  input  logic [0:ADDR_W-1] in_raddr_b,
  output logic [0:WIDTH-1]  out_a,
  output logic [0:WIDTH-1]  out_b,
  output logic              out_valid_a,
  output logic              out_valid_b
);

  logic [0:DEPTH*WIDTH-1] data_bus;
  logic [0:DEPTH-1]       valid_bus;
  logic                   wr_en;

  assign wr_en = in_load && !in_clear;

  // Per-entry storage with its own write decode.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [0:WIDTH-1] q;
    logic             v;
    logic             hit;

    assign hit = wr_en && (in_waddr == ADDR_W'(i));

    always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
        q <= '0;
        v <= 1'b0;
      end else if (in_clear) begin
        q <= '0;
        v <= 1'b0;
      end else if (hit) begin
        q <= in_d;
        v <= 1'b1;
      end
    end

    assign data_bus[i*WIDTH +: WIDTH] = q;
    assign valid_bus[i]               = v;
  end

  logic [0:WIDTH-1] mem_a, mem_b;
  logic             vmem_a, vmem_b;

  _muxnway #(.N(DEPTH), .WIDTH(WIDTH)) u_mux_a (
    .out_y  (mem_a),
    .in_bus (data_bus),
    .sel    (in_raddr_a)
  );

  _muxnway #(.N(DEPTH), .WIDTH(WIDTH)) u_mux_b (
    .out_y  (mem_b),
    .in_bus (data_bus),
    .sel    (in_raddr_b)
  );

  _muxnway #(.N(DEPTH), .WIDTH(1)) u_vmux_a (
    .out_y  (vmem_a),
    .in_bus (valid_bus),
    .sel    (in_raddr_a)
  );

  _muxnway #(.N(DEPTH), .WIDTH(1)) u_vmux_b (
    .out_y  (vmem_b),
    .in_bus (valid_bus),
    .sel    (in_raddr_b)
  );

  // Forwarding is qualified with reset so a write in flight when reset
  // asserts is not visible on the read ports; wr_en already excludes clear.
  logic fwd_a, fwd_b;
  assign fwd_a = (BYPASS != BYP_OFF) && in_rst_n && wr_en && (in_waddr == in_raddr_a);
  assign fwd_b = (BYPASS != BYP_OFF) && in_rst_n && wr_en && (in_waddr == in_raddr_b);

  logic [0:WIDTH-1] comb_a, comb_b;
  logic             comb_va, comb_vb;

  assign comb_a  = fwd_a ? in_d : mem_a;
  assign comb_b  = fwd_b ? in_d : mem_b;
  assign comb_va = fwd_a | vmem_a;
  assign comb_vb = fwd_b | vmem_b;

  if (READ_REG == RD_REG) begin : g_rd_reg
    always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
        out_a       <= '0;
        out_b       <= '0;
        out_valid_a <= 1'b0;
        out_valid_b <= 1'b0;
      end else if (in_clear) begin
        out_a       <= '0;
        out_b       <= '0;
        out_valid_a <= 1'b0;
        out_valid_b <= 1'b0;
      end else begin
        out_a       <= comb_a;
        out_b       <= comb_b;
        out_valid_a <= comb_va;
        out_valid_b <= comb_vb;
      end
    end
  end else begin : g_rd_comb
    assign out_a       = comb_a;
    assign out_b       = comb_b;
    assign out_valid_a = comb_va;
    assign out_valid_b = comb_vb;
  end

endmodule

// File: tb/tb__regfile_nway.sv
module tb__regfile_nway;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- 16x8 instances sharing one stimulus ----------------
  logic        load, clear;
  logic [0:2]  waddr, ra, rb;
  logic [0:15] d;

  logic [0:15] c1_a, c1_b, c0_a, c0_b, r1_a, r1_b, r0_a, r0_b;
  logic        c1_va, c1_vb, c0_va, c0_vb, r1_va, r1_vb, r0_va, r0_vb;

  _regfile_nway #(.WIDTH(16), .DEPTH(8), .READ_REG(0), .BYPASS(1)) u_c1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_load(load), .in_waddr(waddr), .in_d(d),
    .in_clear(clear), .in_raddr_a(ra), .in_raddr_b(rb),
    .out_a(c1_a), .out_b(c1_b), .out_valid_a(c1_va), .out_valid_b(c1_vb));

  _regfile_nway #(.WIDTH(16), .DEPTH(8), .READ_REG(0), .BYPASS(0)) u_c0 (
    .in_clk(clk), .in_rst_n(rst_n), .in_load(load), .in_waddr(waddr), .in_d(d),
    .in_clear(clear), .in_raddr_a(ra), .in_raddr_b(rb),
    .out_a(c0_a), .out_b(c0_b), .out_valid_a(c0_va), .out_valid_b(c0_vb));

  _regfile_nway #(.WIDTH(16), .DEPTH(8), .READ_REG(1), .BYPASS(1)) u_r1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_load(load), .in_waddr(waddr), .in_d(d),
    .in_clear(clear), .in_raddr_a(ra), .in_raddr_b(rb),
    .out_a(r1_a), .out_b(r1_b), .out_valid_a(r1_va), .out_valid_b(r1_vb));

  _regfile_nway #(.WIDTH(16), .DEPTH(8), .READ_REG(1), .BYPASS(0)) u_r0 (
    .in_clk(clk), .in_rst_n(rst_n), .in_load(load), .in_waddr(waddr), .in_d(d),
    .in_clear(clear), .in_raddr_a(ra), .in_raddr_b(rb),
    .out_a(r0_a), .out_b(r0_b), .out_valid_a(r0_va), .out_valid_b(r0_vb));

  // ---------------- parameter-sweep instances ----------------
  logic       s1_load, s1_clear;
  logic [0:0] s1_waddr, s1_ra, s1_rb, s1_d, s1_a, s1_b;
  logic       s1_va, s1_vb;

  _regfile_nway #(.WIDTH(1), .DEPTH(2), .READ_REG(0), .BYPASS(1)) u_w1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_load(s1_load), .in_waddr(s1_waddr), .in_d(s1_d),
    .in_clear(s1_clear), .in_raddr_a(s1_ra), .in_raddr_b(s1_rb),
    .out_a(s1_a), .out_b(s1_b), .out_valid_a(s1_va), .out_valid_b(s1_vb));

  logic        s32_load, s32_clear;
  logic [0:5]  s32_waddr, s32_ra, s32_rb;
  logic [0:31] s32_d, s32_a, s32_b;
  logic        s32_va, s32_vb;

  _regfile_nway #(.WIDTH(32), .DEPTH(64), .READ_REG(1), .BYPASS(0)) u_w32 (
    .in_clk(clk), .in_rst_n(rst_n), .in_load(s32_load), .in_waddr(s32_waddr), .in_d(s32_d),
    .in_clear(s32_clear), .in_raddr_a(s32_ra), .in_raddr_b(s32_rb),
    .out_a(s32_a), .out_b(s32_b), .out_valid_a(s32_va), .out_valid_b(s32_vb));

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          vectors;
  int          miscompares;

  logic        m1  [0:1];
  logic        v1  [0:1];
  logic [31:0] m32 [0:63];
  logic        v32 [0:63];

  function automatic logic [63:0] pk(input logic v, input logic [31:0] dat);
    return {31'b0, v, dat};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got);
    logic [63:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %0h, nothing expected in queue", tag, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, e);
      end
    end
  endtask

  // Push one directed expectation and compare it straight away.
  task automatic expect_chk(input string tag, input logic got_v, input logic [31:0] got_d,
                            input logic exp_v, input logic [31:0] exp_d);
    exp_q.push_back(pk(exp_v, exp_d));
    chk(tag, pk(got_v, got_d));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic f;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    load = 1'b0; clear = 1'b0; waddr = '0; d = '0; ra = 3'd3; rb = 3'd5;
    s1_load = 1'b0; s1_clear = 1'b0; s1_waddr = '0; s1_d = '0; s1_ra = '0; s1_rb = '0;
    s32_load = 1'b0; s32_clear = 1'b0; s32_waddr = '0; s32_d = '0; s32_ra = '0; s32_rb = '0;

    // Reset state, before any edge
    #2;
    expect_chk("rst_c1_a", c1_va, 32'(c1_a), 1'b0, 32'h0);
    expect_chk("rst_c1_b", c1_vb, 32'(c1_b), 1'b0, 32'h0);
    expect_chk("rst_c0_a", c0_va, 32'(c0_a), 1'b0, 32'h0);
    expect_chk("rst_r1_a", r1_va, 32'(r1_a), 1'b0, 32'h0);
    expect_chk("rst_r0_b", r0_vb, 32'(r0_b), 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill addr i with 16'h1000+i
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; waddr = 3'(i); d = 16'(16'h1000 + i);
      @(posedge clk); #1;
    end
    load = 1'b0;

    // Readback sweep: port A ascending, port B descending
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i);
      #1;
      expect_chk("fill_c1_a", c1_va, 32'(c1_a), 1'b1, 32'h1000 + i);
      expect_chk("fill_c1_b", c1_vb, 32'(c1_b), 1'b1, 32'h1000 + 7 - i);
      expect_chk("fill_c0_a", c0_va, 32'(c0_a), 1'b1, 32'h1000 + i);
      expect_chk("fill_c0_b", c0_vb, 32'(c0_b), 1'b1, 32'h1000 + 7 - i);
      @(posedge clk); #1;
      expect_chk("fill_r1_a", r1_va, 32'(r1_a), 1'b1, 32'h1000 + i);
      expect_chk("fill_r1_b", r1_vb, 32'(r1_b), 1'b1, 32'h1000 + 7 - i);
      expect_chk("fill_r0_a", r0_va, 32'(r0_a), 1'b1, 32'h1000 + i);
      expect_chk("fill_r0_b", r0_vb, 32'(r0_b), 1'b1, 32'h1000 + 7 - i);
    end

    // Bypass: addr 5 = 0005, then write A5A5 while reading addr 5
    load = 1'b1; waddr = 3'd5; d = 16'h0005;
    @(posedge clk); #1;
    d = 16'hA5A5; ra = 3'd5; rb = 3'd0;
    #1;
    expect_chk("byp_c1_same_cycle", c1_va, 32'(c1_a), 1'b1, 32'hA5A5);
    expect_chk("nobyp_c0_before_edge", c0_va, 32'(c0_a), 1'b1, 32'h0005);
    @(posedge clk); #1;
    load = 1'b0;
    expect_chk("nobyp_c0_after_edge", c0_va, 32'(c0_a), 1'b1, 32'hA5A5);
    expect_chk("byp_r1_write_first", r1_va, 32'(r1_a), 1'b1, 32'hA5A5);
    expect_chk("nobyp_r0_read_first", r0_va, 32'(r0_a), 1'b1, 32'h0005);

    // Registered read: write 1234 to addr 2 while reading it
    load = 1'b1; waddr = 3'd2; d = 16'h1234; ra = 3'd2;
    @(posedge clk); #1;
    load = 1'b0;
    expect_chk("rreg_r1_edge1", r1_va, 32'(r1_a), 1'b1, 32'h1234);
    expect_chk("rreg_r0_edge1", r0_va, 32'(r0_a), 1'b1, 32'h1002);
    @(posedge clk); #1;
    expect_chk("rreg_r0_edge2", r0_va, 32'(r0_a), 1'b1, 32'h1234);
    expect_chk("rreg_r1_edge2", r1_va, 32'(r1_a), 1'b1, 32'h1234);

    // Clear together with a load to addr 1
    clear = 1'b1; load = 1'b1; waddr = 3'd1; d = 16'hFFFF; ra = 3'd1; rb = 3'd1;
    #1;
    expect_chk("clr_c1_no_fwd", c1_va, 32'(c1_a), 1'b1, 32'h1001);
    expect_chk("clr_c0_old", c0_vb, 32'(c0_b), 1'b1, 32'h1001);
    @(posedge clk); #1;
    clear = 1'b0; load = 1'b0;
    expect_chk("clr_r1_a", r1_va, 32'(r1_a), 1'b0, 32'h0);
    expect_chk("clr_r0_b", r0_vb, 32'(r0_b), 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(i);
      #1;
      expect_chk("clr_c1_a", c1_va, 32'(c1_a), 1'b0, 32'h0);
      expect_chk("clr_c0_b", c0_vb, 32'(c0_b), 1'b0, 32'h0);
    end
    rb = 3'd1;
    repeat (2) begin
      @(posedge clk); #1;
      expect_chk("clr_hold_c1_b", c1_vb, 32'(c1_b), 1'b0, 32'h0);
      expect_chk("clr_hold_r1_b", r1_vb, 32'(r1_b), 1'b0, 32'h0);
    end
    load = 1'b1; waddr = 3'd1; d = 16'h00AA; ra = 3'd6;
    #1;
    expect_chk("rewr_c0_b_pre", c0_vb, 32'(c0_b), 1'b0, 32'h0);
    expect_chk("rewr_c1_b_fwd", c1_vb, 32'(c1_b), 1'b1, 32'h00AA);
    @(posedge clk); #1;
    waddr = 3'd6; d = 16'h6666;
    expect_chk("rewr_c0_b_post", c0_vb, 32'(c0_b), 1'b1, 32'h00AA);
    expect_chk("rewr_r0_b", r0_vb, 32'(r0_b), 1'b0, 32'h0);
    expect_chk("rewr_r1_b", r1_vb, 32'(r1_b), 1'b1, 32'h00AA);
    @(posedge clk); #1;
    load = 1'b0;
    expect_chk("rewr_c0_a6", c0_va, 32'(c0_a), 1'b1, 32'h6666);

    // Asynchronous reset pulse in the middle of a write of BEEF to addr 3
    load = 1'b1; waddr = 3'd3; d = 16'hBEEF; ra = 3'd3; rb = 3'd6;
    #1;
    expect_chk("mid_c1_fwd_pre", c1_va, 32'(c1_a), 1'b1, 32'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    expect_chk("arst_c1_a", c1_va, 32'(c1_a), 1'b0, 32'h0);
    expect_chk("arst_c1_b", c1_vb, 32'(c1_b), 1'b0, 32'h0);
    expect_chk("arst_c0_a", c0_va, 32'(c0_a), 1'b0, 32'h0);
    expect_chk("arst_c0_b", c0_vb, 32'(c0_b), 1'b0, 32'h0);
    expect_chk("arst_r1_a", r1_va, 32'(r1_a), 1'b0, 32'h0);
    expect_chk("arst_r1_b", r1_vb, 32'(r1_b), 1'b0, 32'h0);
    expect_chk("arst_r0_a", r0_va, 32'(r0_a), 1'b0, 32'h0);
    expect_chk("arst_r0_b", r0_vb, 32'(r0_b), 1'b0, 32'h0);
    @(posedge clk); #1;
    expect_chk("arst_hold_r1_a", r1_va, 32'(r1_a), 1'b0, 32'h0);
    rst_n = 1'b1; load = 1'b0;
    #1;
    expect_chk("arst_rel_c1_a3", c1_va, 32'(c1_a), 1'b0, 32'h0);
    expect_chk("arst_rel_c0_b6", c0_vb, 32'(c0_b), 1'b0, 32'h0);
    @(posedge clk); #1;
    expect_chk("arst_rel_r1_a3", r1_va, 32'(r1_a), 1'b0, 32'h0);
    expect_chk("arst_rel_r0_b6", r0_vb, 32'(r0_b), 1'b0, 32'h0);

    // Random sweep of WIDTH=1/DEPTH=2 (comb, bypass) and WIDTH=32/DEPTH=64
    // (registered, read-first) against array models.
    for (int i = 0; i < 2; i++) begin m1[i] = 1'b0; v1[i] = 1'b0; end
    for (int i = 0; i < 64; i++) begin m32[i] = 32'h0; v32[i] = 1'b0; end
    exp_q.push_back(pk(1'b0, 32'h0));
    exp_q.push_back(pk(1'b0, 32'h0));
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      if (s1_clear) begin
        for (int i = 0; i < 2; i++) begin m1[i] = 1'b0; v1[i] = 1'b0; end
      end else if (s1_load) begin
        m1[s1_waddr] = s1_d[0]; v1[s1_waddr] = 1'b1;
      end
      if (s32_clear) begin
        for (int i = 0; i < 64; i++) begin m32[i] = 32'h0; v32[i] = 1'b0; end
      end else if (s32_load) begin
        m32[s32_waddr] = s32_d; v32[s32_waddr] = 1'b1;
      end
      chk("rnd_w32_a", pk(s32_va, s32_a));
      chk("rnd_w32_b", pk(s32_vb, s32_b));

      s1_load   = ($urandom_range(0, 3) != 0);
      s1_clear  = ($urandom_range(0, 49) == 0);
      s1_waddr  = 1'($urandom_range(0, 1));
      s1_d      = 1'($urandom_range(0, 1));
      s1_ra     = 1'($urandom_range(0, 1));
      s1_rb     = 1'($urandom_range(0, 1));
      s32_load  = ($urandom_range(0, 3) != 0);
      s32_clear = ($urandom_range(0, 99) == 0);
      s32_waddr = 6'($urandom_range(0, 63));
      s32_d     = $urandom();
      s32_ra    = 6'($urandom_range(0, 63));
      s32_rb    = ($urandom_range(0, 3) == 0) ? s32_waddr : 6'($urandom_range(0, 63));
      #1;

      f = s1_load && !s1_clear && (s1_waddr == s1_ra);
      exp_q.push_back(pk(f | v1[s1_ra], f ? 32'(s1_d) : 32'(m1[s1_ra])));
      chk("rnd_w1_a", pk(s1_va, 32'(s1_a)));
      f = s1_load && !s1_clear && (s1_waddr == s1_rb);
      exp_q.push_back(pk(f | v1[s1_rb], f ? 32'(s1_d) : 32'(m1[s1_rb])));
      chk("rnd_w1_b", pk(s1_vb, 32'(s1_b)));

      exp_q.push_back(s32_clear ? 64'h0 : pk(v32[s32_ra], m32[s32_ra]));
      exp_q.push_back(s32_clear ? 64'h0 : pk(v32[s32_rb], m32[s32_rb]));
    end
    @(posedge clk); #1;
    chk("rnd_w32_a_last", pk(s32_va, s32_a));
    chk("rnd_w32_b_last", pk(s32_vb, s32_b));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
